// File: rtl/two_channel_queue_pkg.sv
// ============================================================================
// Module   : two_channel_queue_pkg
// Brief    : Shared types, constants and grant-legality helper for the
//            two-channel request queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package two_channel_queue_pkg;

  localparam int N_CHANNELS = 2;

  typedef logic chan_idx_t;

  // A grant is legal only when it is one-hot and lands on a channel that is
  // currently requesting.
  function automatic logic is_legal_grant(
    input logic [N_CHANNELS-1:0] requests,
    input logic [N_CHANNELS-1:0] grants
  );
    return ((grants == 2'b01) && requests[0]) ||
           ((grants == 2'b10) && requests[1]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered empty/full and a
//            combinational head-of-queue read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only entries behind a valid count are ever read out.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/two_channel_request_queue.sv
// ============================================================================
// Module   : two_channel_request_queue
// Brief    : Two per-channel FIFOs feeding a round-robin arbiter; pops the
//            granted head onto a single output and flags grant misuse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module two_channel_request_queue
  import two_channel_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CHANNELS-1:0]         in_valid,
  input  logic [N_CHANNELS*WIDTH-1:0]   in_data,
  output logic [N_CHANNELS-1:0]         in_ready,
  output logic [N_CHANNELS-1:0]         requests,
  input  logic [N_CHANNELS-1:0]         grants,
  output logic                          out_valid,
  output chan_idx_t                     out_channel,
  output logic [WIDTH-1:0]              out_data,
  output logic                          grant_err
);

  logic [WIDTH-1:0]      head_data [N_CHANNELS];
  logic [N_CHANNELS-1:0] fifo_empty;
  logic [N_CHANNELS-1:0] fifo_full;
  logic [N_CHANNELS-1:0] pop;
  logic                  legal_grant;
  logic                  grant_err_q, grant_err_d;

  assign legal_grant = is_legal_grant(requests, grants);

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_fifo
    assign in_ready[g] = ~fifo_full[g];
    assign requests[g] = ~fifo_empty[g];
    assign pop[g]      = legal_grant & grants[g];

    sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[g] & in_ready[g]),
      .push_data (in_data[g*WIDTH +: WIDTH]),
      .pop       (pop[g]),
      .head_data (head_data[g]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g])
    );
  end

  always_comb begin
    out_valid   = 1'b0;
    out_channel = 1'b0;
    out_data    = '0;
    if (legal_grant) begin
      out_valid   = 1'b1;
      out_channel = chan_idx_t'(grants[1]);
      out_data    = head_data[grants[1]];
    end
  end

  // Any non-zero grant that is not legal latches the error until reset.
  always_comb begin
    grant_err_d = grant_err_q | ((grants != '0) && !legal_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_err_q <= 1'b0;
    end else begin
      grant_err_q <= grant_err_d;
    end
  end

  assign grant_err = grant_err_q;

endmodule

`default_nettype wire

// File: tb/tb_two_channel_request_queue.sv
// ============================================================================
// Module   : tb_two_channel_request_queue
// Brief    : Scoreboard bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_two_channel_request_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic [1:0]        in_valid;
  logic [2*WIDTH-1:0] in_data;
  logic [1:0]        in_ready;
  logic [1:0]        requests;
  logic [1:0]        grants;
  logic              out_valid;
  logic              out_channel;
  logic [WIDTH-1:0]  out_data;
  logic              grant_err;

  two_channel_request_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .requests    (requests),
    .grants      (grants),
    .out_valid   (out_valid),
    .out_channel (out_channel),
    .out_data    (out_data),
    .grant_err   (grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one plain queue per channel plus the sticky error.
  logic [WIDTH-1:0] mq0[$];
  logic [WIDTH-1:0] mq1[$];
  bit               merr = 1'b0;
  bit               model_valid = 1'b0;

  // Scoreboard of popped entries {channel, data}.
  logic [WIDTH:0]   exp_q[$];

  logic [1:0] e_ready, e_req;
  logic       e_err, e_valid;
  bit         e_live = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, publishes the expected outputs for it and
  // advances the model across the following clock edge.
  task automatic step(input logic r, input logic [1:0] v, input logic [15:0] d,
                      input logic [1:0] g);
    int  s0, s1;
    bit  legal, acc0, acc1;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    grants   = g;
    s0 = mq0.size();
    s1 = mq1.size();
    legal = ((g == 2'b01) && (s0 > 0)) || ((g == 2'b10) && (s1 > 0));
    e_ready = {s1 < DEPTH, s0 < DEPTH};
    e_req   = {s1 > 0, s0 > 0};
    e_err   = merr;
    e_valid = legal;
    e_live  = model_valid;
    if (legal && model_valid) begin
      if (g[1]) exp_q.push_back({1'b1, mq1[0]});
      else      exp_q.push_back({1'b0, mq0[0]});
    end
    if (r) begin
      mq0.delete();
      mq1.delete();
      merr = 1'b0;
      model_valid = 1'b1;
    end else begin
      acc0 = v[0] && (s0 < DEPTH);
      acc1 = v[1] && (s1 < DEPTH);
      if (legal) begin
        if (g[1]) void'(mq1.pop_front());
        else      void'(mq0.pop_front());
      end
      if (acc0) mq0.push_back(d[7:0]);
      if (acc1) mq1.push_back(d[15:8]);
      if ((g != 2'b00) && !legal) merr = 1'b1;
    end
  endtask

  // Monitor: samples just before each rising edge.
  always begin
    logic [WIDTH:0] exp_item;
    @(negedge clk);
    #4;
    if (e_live) begin
      check("in_ready", 32'(in_ready), 32'(e_ready));
      check("requests", 32'(requests), 32'(e_req));
      check("grant_err", 32'(grant_err), 32'(e_err));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(1), 32'(0));
        end else begin
          exp_item = exp_q.pop_front();
          check("out_channel", 32'(out_channel), 32'(exp_item[WIDTH]));
          check("out_data", 32'(out_data), 32'(exp_item[WIDTH-1:0]));
        end
      end else begin
        if (e_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        check("idle_channel", 32'(out_channel), 32'(0));
        check("idle_data", 32'(out_data), 32'(0));
      end
    end
  end

  initial begin
    int         last;
    int         sel;
    logic [7:0] a, b;
    logic [1:0] g;
    rst = 1'b1; in_valid = '0; in_data = '0; grants = '0;

    // Reset with pushes asserted
    step(1'b1, 2'b11, 16'hFFFF, 2'b00);
    step(1'b1, 2'b11, 16'hFFFF, 2'b00);
    step(1'b0, 2'b00, 16'h0000, 2'b00);

    // Ordering on channel 0
    step(1'b0, 2'b01, 16'h0011, 2'b00);
    step(1'b0, 2'b01, 16'h0022, 2'b00);
    step(1'b0, 2'b01, 16'h0033, 2'b00);
    repeat (3) step(1'b0, 2'b00, 16'h0000, 2'b01);
    step(1'b0, 2'b00, 16'h0000, 2'b00);

    // Fill channel 1, then push-while-full with a simultaneous pop
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'hC0 + i);
      step(1'b0, 2'b10, {b, 8'h00}, 2'b00);
    end
    step(1'b0, 2'b10, 16'hEE00, 2'b10);
    step(1'b0, 2'b00, 16'h0000, 2'b00);
    repeat (3) step(1'b0, 2'b00, 16'h0000, 2'b10);

    // Round-robin arbiter loop over preloaded channels
    for (int i = 0; i < 3; i++) begin
      a = 8'(8'hA0 + i);
      b = 8'(8'hB0 + i);
      step(1'b0, 2'b11, {b, a}, 2'b00);
    end
    last = 1;
    for (int i = 0; i < 6; i++) begin
      if (last == 1) g = (mq0.size() > 0) ? 2'b01 : ((mq1.size() > 0) ? 2'b10 : 2'b00);
      else           g = (mq1.size() > 0) ? 2'b10 : ((mq0.size() > 0) ? 2'b01 : 2'b00);
      if (g != 2'b00) last = g[1] ? 1 : 0;
      step(1'b0, 2'b00, 16'h0000, g);
    end

    // Push into empty channel with same-cycle grant: no bypass
    step(1'b0, 2'b01, 16'h005A, 2'b01);
    step(1'b0, 2'b00, 16'h0000, 2'b01);
    step(1'b0, 2'b00, 16'h0000, 2'b00);
    step(1'b1, 2'b00, 16'h0000, 2'b00);

    // Double grant with both channels non-empty
    step(1'b0, 2'b11, 16'h7766, 2'b00);
    step(1'b0, 2'b00, 16'h0000, 2'b11);
    step(1'b0, 2'b00, 16'h0000, 2'b00);
    step(1'b0, 2'b00, 16'h0000, 2'b01);
    step(1'b0, 2'b00, 16'h0000, 2'b10);
    step(1'b1, 2'b00, 16'h0000, 2'b00);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        if (mq0.size() > 0 && mq1.size() > 0) g = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        else if (mq0.size() > 0)              g = 2'b01;
        else if (mq1.size() > 0)              g = 2'b10;
        else                                  g = 2'b00;
      end else if (sel < 9) begin
        g = 2'b00;
      end else begin
        g = 2'($urandom_range(1, 3));
      end
      step(($urandom_range(0, 149) == 0), 2'($urandom), 16'($urandom), g);
    end
    step(1'b0, 2'b00, 16'h0000, 2'b00);

    @(negedge clk);
    #6;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/two_channel_request_queue.md
Name: two_channel_request_queue

Overview:
Upstream stage of the 2-request round-robin arbiter. Buffers transactions from two independent producers in per-channel FIFOs and presents one request bit per non-empty channel. Consumes the arbiter's grants and pops the granted head entry onto a single output. Provides in_data to the arbiter's consumer in grant order.

Parameters:
WIDTH, 8, payload width per channel.
DEPTH, 4, entries per channel FIFO; power of two, minimum 2.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  2  per-channel push request; bit i is channel i.
in_data  input  2*WIDTH  channel 1 in upper WIDTH bits, channel 0 in lower WIDTH bits.
in_ready  output  2  per-channel FIFO not full.
requests  output  2  per-channel FIFO not empty; drives arbiter requests.
grants  input  2  from arbiter; one-hot or zero.
out_valid  output  1  a legal grant popped an entry this cycle.
out_channel  output  1  index of the popped channel.
out_data  output  WIDTH  head entry of the popped channel.
grant_err  output  1  sticky protocol-error flag.

Behaviour:
- One clock, clk; synchronous active-high reset, rst. All state updates on posedge clk only.
- Reset clears both FIFOs: pointers and counts go to 0, and grant_err goes to 0.
  - After reset: in_ready=2'b11, requests=2'b00, out_valid=0, out_channel=0, out_data=0.
- Reset mid-operation discards all buffered entries. A push or grant in the reset cycle has no effect.
- Push on channel i: in_valid[i] & in_ready[i]; the entry is written at the tail.
  - in_ready[i] = (count_i != DEPTH). It is registered-state derived and does not depend on same-cycle pop.
  - When full, no push is accepted, even if a pop happens the same cycle.
- requests[i] = (count_i != 0), registered-state derived. No bypass: a push into an empty FIFO raises requests[i] the next cycle.
- Legal grant: grants is one-hot, and the selected channel has requests set.
  - Combinationally in the same cycle: out_valid=1, out_channel=granted index, out_data=head of that channel.
  - The head pops on the next edge. Zero-cycle latency from grant to output.
- grants==2'b00: out_valid=0, out_channel=0, out_data=0, no pop.
- Illegal grant, meaning grants==2'b11, or a one-hot grant to an empty channel:
  - out_valid=0, out_channel=0, out_data=0, no pop.
  - grant_err is set on the next edge and held until rst.
- Push and legal pop on the same channel in the same cycle: count unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Count width: $clog2(DEPTH+1) bits.
- Entries leave each channel in FIFO order. Channels are independent apart from the shared output.

Decomposition:
- Package two_channel_queue_pkg:
  - typedef chan_idx_t (1 bit).
  - localparam N_CHANNELS=2.
  - function is_legal_grant(requests, grants).
- Sub-module sync_fifo (WIDTH, DEPTH):
  - Ports: clk, rst, push, push_data, pop, head_data, empty, full.
  - Instantiated twice.
- Top level holds only output muxing and grant_err.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=2'b11 -> after reset in_ready=2'b11, requests=2'b00, grant_err=0, out_valid=0.
- Ordering: push 0x11, 0x22, 0x33 on channel 0, then grant 2'b01 for 3 cycles -> out_data 0x11, 0x22, 0x33 with out_channel=0; requests[0] falls after the third pop.
- Full: push 4 entries on channel 1 with DEPTH=4 -> in_ready[1]=0.
  - A 5th push with a simultaneous pop is not accepted.
  - After the pop, in_ready[1]=1 next cycle.
- Arbiter loop: connect a round_robin arbiter with channel 0 preloaded 0xA0..0xA2 and channel 1 preloaded 0xB0..0xB2 -> out_data 0xA0, 0xB0, 0xA1, 0xB1, 0xA2, 0xB2.
- No bypass: push 0x5A into an empty channel 0 while grants=2'b01 in the same cycle -> out_valid=0 and grant_err=1 next cycle; 0x5A is still popped on a later legal grant.
- Illegal grant: grants=2'b11 with both channels non-empty -> out_valid=0, counts unchanged, grant_err=1 until rst.
